// File: rtl/uart128_tx_sched_if.sv
// Handshake bundle between the requesters, the UART core and the
// round-robin transmit scheduler.
interface uart128_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*128-1:0] req_data;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     done;
    logic [NUM_REQ-1:0]     err;
    logic                   busy;
    logic                   en_tx;
    logic [127:0]           tx_data;
    logic                   u_tx_done;

    modport master (
        input  req,
        input  req_data,
        input  u_tx_done,
        output grant,
        output done,
        output err,
        output busy,
        output en_tx,
        output tx_data
    );

    modport slave (
        output req,
        output req_data,
        output u_tx_done,
        input  grant,
        input  done,
        input  err,
        input  busy,
        input  en_tx,
        input  tx_data
    );
endinterface

// File: rtl/uart128_tx_sched.sv
// Round-robin scheduler sharing one 128-bit UART transmit path,
// with completion edge detect, watchdog abort and idle gap.
module uart128_tx_sched #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYC     = 16
) (
    input  logic                clk,
    input  logic                reset,
    uart128_tx_sched_if.master  bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        own_q, own_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [GW-1:0]        gcnt_q, gcnt_d;
    logic                 hist_q, hist_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 en_q, en_d;
    logic [127:0]         data_q, data_d;

    logic                 found;
    logic [PW-1:0]        win;
    logic [PW-1:0]        ptr_nxt;
    logic                 rise;

    // First requester at or above ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign rise    = bus.u_tx_done && !hist_q;
    assign ptr_nxt = (own_q == PW'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        hist_d  = bus.u_tx_done;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        busy_d  = busy_q;
        en_d    = en_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = XFER;
                    own_d        = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    data_d       = bus.req_data[128*win +: 128];
                    en_d         = 1'b1;
                    busy_d       = 1'b1;
                    tcnt_d       = '0;
                end
            end
            XFER: begin
                // Completion takes priority over a coincident timeout.
                if (rise || tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    if (rise) begin
                        done_d = grant_q;
                    end else begin
                        err_d = grant_q;
                    end
                    grant_d = '0;
                    en_d    = 1'b0;
                    ptr_d   = ptr_nxt;
                    gcnt_d  = '0;
                    state_d = GAP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gcnt_q == GW'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                en_d    = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            hist_q  <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            hist_q  <= hist_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            data_q  <= data_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
    assign bus.en_tx   = en_q;
    assign bus.tx_data = data_q;
endmodule

// File: tb/tb_uart128_tx_sched.sv
// Directed bench for the round-robin UART transmit scheduler.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_uart128_tx_sched;
    localparam int NR = 4;
    localparam int TO = 4096;
    localparam int GP = 16;
    localparam logic [127:0] W0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RB = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] WH = 128'h0123456789abcdef0123456789abcdef;

    logic clk;
    logic reset;
    int   nvec;
    int   nerr;
    logic [127:0] w [NR];

    uart128_tx_sched_if #(.NUM_REQ(NR)) bus ();

    uart128_tx_sched #(
        .NUM_REQ    (NR),
        .TIMEOUT_CYC(TO),
        .GAP_CYC    (GP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.req = '0;
        bus.req_data = '0;
        bus.u_tx_done = 1'b0;
        tick(2);
        nvec++; if (bus.grant !== 4'b0000) begin nerr++; $display("FAIL rst_grant: got %b exp 0000", bus.grant); end
        nvec++; if (bus.done !== 4'b0000 || bus.err !== 4'b0000) begin nerr++; $display("FAIL rst_pulse: done %b err %b exp 0000", bus.done, bus.err); end
        nvec++; if (bus.busy !== 1'b0 || bus.en_tx !== 1'b0) begin nerr++; $display("FAIL rst_busy_en: busy %b en %b exp 0 0", bus.busy, bus.en_tx); end
        nvec++; if (bus.tx_data !== 128'h0) begin nerr++; $display("FAIL rst_data: got %h exp 0", bus.tx_data); end
        reset = 1'b1;
        tick();
        nvec++; if (bus.en_tx !== 1'b0) begin nerr++; $display("FAIL idle_no_req: en %b exp 0", bus.en_tx); end
    endtask

    task automatic test_single();
        bus.req_data = '0;
        bus.req_data[127:0] = W0;
        bus.req = 4'b0001;
        tick();
        nvec++; if (bus.en_tx !== 1'b1 || bus.grant !== 4'b0001) begin nerr++; $display("FAIL single_grant: en %b grant %b exp 1 0001", bus.en_tx, bus.grant); end
        nvec++; if (bus.tx_data !== W0) begin nerr++; $display("FAIL single_data: got %h exp %h", bus.tx_data, W0); end
        tick(179);
        nvec++; if (bus.en_tx !== 1'b1 || bus.done !== 4'b0000) begin nerr++; $display("FAIL single_hold: en %b done %b exp 1 0000", bus.en_tx, bus.done); end
        bus.u_tx_done = 1'b1;
        tick();
        nvec++; if (bus.done !== 4'b0001) begin nerr++; $display("FAIL single_done: got %b exp 0001", bus.done); end
        nvec++; if (bus.en_tx !== 1'b0 || bus.grant !== 4'b0000) begin nerr++; $display("FAIL single_release: en %b grant %b exp 0 0000", bus.en_tx, bus.grant); end
        bus.req = '0;
        for (int i = 1; i < GP; i++) begin
            tick();
            nvec++; if (bus.busy !== 1'b1 || bus.en_tx !== 1'b0 || bus.done !== 4'b0000) begin nerr++; $display("FAIL single_gap%0d: busy %b en %b done %b exp 1 0 0000", i, bus.busy, bus.en_tx, bus.done); end
        end
        bus.u_tx_done = 1'b0;
        tick();
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL single_gap_end: busy %b exp 0", bus.busy); end
    endtask

    task automatic test_rr();
        logic [3:0] eg;
        reset = 1'b0;
        bus.req = '0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) w[i] = RB + 128'(i);
        bus.req_data = {w[3], w[2], w[1], w[0]};
        bus.req = 4'b1111;
        tick();
        for (int n = 0; n < 5; n++) begin
            eg = 4'b0001 << (n % 4);
            nvec++; if (bus.en_tx !== 1'b1 || bus.grant !== eg) begin nerr++; $display("FAIL rr_grant%0d: en %b grant %b exp 1 %b", n, bus.en_tx, bus.grant, eg); end
            nvec++; if (bus.tx_data !== w[n % 4]) begin nerr++; $display("FAIL rr_data%0d: got %h exp %h", n, bus.tx_data, w[n % 4]); end
            tick(3);
            bus.u_tx_done = 1'b1;
            tick();
            bus.u_tx_done = 1'b0;
            nvec++; if (bus.done !== eg) begin nerr++; $display("FAIL rr_done%0d: got %b exp %b", n, bus.done, eg); end
            if (n == 4) bus.req = '0;
            tick(GP);
            nvec++; if (bus.en_tx !== 1'b0) begin nerr++; $display("FAIL rr_gap%0d: en %b exp 0", n, bus.en_tx); end
            if (n < 4) tick();
        end
    endtask

    task automatic test_skip_wrap();
        bus.req = 4'b0010;
        tick();
        nvec++; if (bus.grant !== 4'b0010) begin nerr++; $display("FAIL skip_first: got %b exp 0010", bus.grant); end
        bus.u_tx_done = 1'b1;
        tick();
        bus.u_tx_done = 1'b0;
        bus.req = 4'b0011;
        tick(GP + 1);
        nvec++; if (bus.grant !== 4'b0001) begin nerr++; $display("FAIL skip_wrap: got %b exp 0001", bus.grant); end
        bus.u_tx_done = 1'b1;
        tick();
        bus.u_tx_done = 1'b0;
        nvec++; if (bus.done !== 4'b0001) begin nerr++; $display("FAIL skip_done0: got %b exp 0001", bus.done); end
        bus.req = 4'b0010;
        tick(GP + 1);
        nvec++; if (bus.grant !== 4'b0010) begin nerr++; $display("FAIL skip_next: got %b exp 0010", bus.grant); end
        bus.u_tx_done = 1'b1;
        tick();
        bus.u_tx_done = 1'b0;
        bus.req = '0;
        tick(GP);
    endtask

    task automatic test_timeout();
        bus.req = 4'b0100;
        tick();
        nvec++; if (bus.grant !== 4'b0100 || bus.en_tx !== 1'b1) begin nerr++; $display("FAIL to_grant: grant %b en %b exp 0100 1", bus.grant, bus.en_tx); end
        tick(TO - 1);
        nvec++; if (bus.en_tx !== 1'b1 || bus.err !== 4'b0000) begin nerr++; $display("FAIL to_early: en %b err %b exp 1 0000", bus.en_tx, bus.err); end
        tick();
        nvec++; if (bus.err !== 4'b0100 || bus.done !== 4'b0000) begin nerr++; $display("FAIL to_err: err %b done %b exp 0100 0000", bus.err, bus.done); end
        nvec++; if (bus.en_tx !== 1'b0 || bus.grant !== 4'b0000) begin nerr++; $display("FAIL to_release: en %b grant %b exp 0 0000", bus.en_tx, bus.grant); end
        bus.req = '0;
        tick();
        nvec++; if (bus.err !== 4'b0000) begin nerr++; $display("FAIL to_pulse_len: err %b exp 0000", bus.err); end
        tick(GP - 1);
    endtask

    task automatic test_data_hold();
        bus.req_data = '0;
        bus.req_data[511:384] = WH;
        bus.req = 4'b1000;
        tick();
        nvec++; if (bus.grant !== 4'b1000 || bus.tx_data !== WH) begin nerr++; $display("FAIL hold_start: grant %b data %h exp 1000 %h", bus.grant, bus.tx_data, WH); end
        bus.req_data = {NR{128'hdeadbeefdeadbeefdeadbeefdeadbeef}};
        bus.req = 4'b0000;
        tick(5);
        nvec++; if (bus.tx_data !== WH || bus.en_tx !== 1'b1) begin nerr++; $display("FAIL hold_data: data %h en %b exp %h 1", bus.tx_data, bus.en_tx, WH); end
        bus.u_tx_done = 1'b1;
        tick();
        bus.u_tx_done = 1'b0;
        nvec++; if (bus.done !== 4'b1000) begin nerr++; $display("FAIL hold_done: got %b exp 1000", bus.done); end
        tick(GP);
    endtask

    task automatic test_race();
        bus.req = 4'b0001;
        tick();
        nvec++; if (bus.grant !== 4'b0001) begin nerr++; $display("FAIL race_grant: got %b exp 0001", bus.grant); end
        tick(TO - 1);
        bus.u_tx_done = 1'b1;
        tick();
        bus.u_tx_done = 1'b0;
        nvec++; if (bus.done !== 4'b0001 || bus.err !== 4'b0000) begin nerr++; $display("FAIL race_win: done %b err %b exp 0001 0000", bus.done, bus.err); end
        bus.req = '0;
        tick(GP);
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b0010;
        tick();
        nvec++; if (bus.grant !== 4'b0010) begin nerr++; $display("FAIL rmid_grant: got %b exp 0010", bus.grant); end
        tick(5);
        reset = 1'b0;
        tick();
        nvec++; if (bus.grant !== 4'b0000 || bus.en_tx !== 1'b0 || bus.busy !== 1'b0) begin nerr++; $display("FAIL rmid_clear: grant %b en %b busy %b exp 0000 0 0", bus.grant, bus.en_tx, bus.busy); end
        nvec++; if (bus.done !== 4'b0000 || bus.err !== 4'b0000 || bus.tx_data !== 128'h0) begin nerr++; $display("FAIL rmid_pulse: done %b err %b data %h exp 0", bus.done, bus.err, bus.tx_data); end
        reset = 1'b1;
        tick();
        nvec++; if (bus.grant !== 4'b0010 || bus.en_tx !== 1'b1) begin nerr++; $display("FAIL rmid_regrant: grant %b en %b exp 0010 1", bus.grant, bus.en_tx); end
        tick(2);
        bus.u_tx_done = 1'b1;
        tick();
        bus.u_tx_done = 1'b0;
        nvec++; if (bus.done !== 4'b0010) begin nerr++; $display("FAIL rmid_done: got %b exp 0010", bus.done); end
        bus.req = '0;
        tick(GP);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        reset = 1'b0;
        bus.req = '0;
        bus.req_data = '0;
        bus.u_tx_done = 1'b0;
        test_reset();
        test_single();
        test_rr();
        test_skip_wrap();
        test_timeout();
        test_data_hold();
        test_race();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
